// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   state_t  - sequencer FSM states
//   COND_*   - execute-condition encodings for InstrCond
//   FLAG_*   - bit positions of Z C N O inside the 4-bit flag word
`timescale 1ns/1ps
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_C      = 3'b011;
    localparam logic [2:0] COND_NC     = 3'b100;
    localparam logic [2:0] COND_N      = 3'b101;
    localparam logic [2:0] COND_O      = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: bundles the instruction handshake, the result
// handshake and the ALU-facing signals of the sequencer.
//   Instr*  - operation request (valid/ready) from the front end
//   Alu*    - registered operands/controls to the ALU, result/flags back
//   Res*    - result handshake back to the front end
//   Flags   - architectural Z C N O register
// Modports: slave = the sequencer, master = its environment.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
);
    logic             InstrValid;
    logic             InstrReady;
    logic [4:0]       InstrFunSel;
    logic             InstrWF;
    logic [2:0]       InstrCond;
    logic [TAG_W-1:0] InstrTag;
    logic [WIDTH-1:0] InstrA;
    logic [WIDTH-1:0] InstrB;

    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [4:0]       AluFunSel;
    logic             AluWF;
    logic [WIDTH-1:0] AluOut;
    logic [3:0]       AluFlags;

    logic             ResValid;
    logic             ResReady;
    logic [WIDTH-1:0] ResData;
    logic [TAG_W-1:0] ResTag;
    logic             ResSkipped;
    logic [3:0]       Flags;

    modport slave (
        input  InstrValid, InstrFunSel, InstrWF, InstrCond, InstrTag, InstrA, InstrB,
        input  AluOut, AluFlags, ResReady,
        output InstrReady, AluA, AluB, AluFunSel, AluWF,
        output ResValid, ResData, ResTag, ResSkipped, Flags
    );

    modport master (
        output InstrValid, InstrFunSel, InstrWF, InstrCond, InstrTag, InstrA, InstrB,
        output AluOut, AluFlags, ResReady,
        input  InstrReady, AluA, AluB, AluFunSel, AluWF,
        input  ResValid, ResData, ResTag, ResSkipped, Flags
    );

endinterface

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: combinational execute-condition check.
//   Flags in  4  current Z C N O flags
//   Cond  in  3  condition code (see COND_* in alu_seq_pkg)
//   take  out 1  high when the operation should execute
`timescale 1ns/1ps
module alu_cond_eval
    import alu_seq_pkg::*;
(
    input  logic [3:0] Flags,
    input  logic [2:0] Cond,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (Cond)
            COND_ALWAYS: take = 1'b1;
            COND_Z:      take = Flags[FLAG_Z];
            COND_NZ:     take = ~Flags[FLAG_Z];
            COND_C:      take = Flags[FLAG_C];
            COND_NC:     take = ~Flags[FLAG_C];
            COND_N:      take = Flags[FLAG_N];
            COND_O:      take = Flags[FLAG_O];
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue-side controller for the ALU. Accepts one
// operation at a time, conditionally drives it into the ALU, captures
// the registered result and flags, and returns it over a result handshake.
//   Clock  in  system clock, rising edge
//   Reset  in  asynchronous active-high reset
//   bus    slave modport of alu_op_sequencer_if (Instr*, Alu*, Res*, Flags)
`timescale 1ns/1ps
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input logic               Clock,
    input logic               Reset,
    alu_op_sequencer_if.slave bus
);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_fun_sel;
    logic             alu_wf;
    logic [WIDTH-1:0] res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_skipped;
    logic [3:0]       flags;
    logic             take;

    alu_cond_eval u_cond_eval (
        .Flags (flags),
        .Cond  (bus.InstrCond),
        .take  (take)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.InstrValid) begin
                    state_next = take ? EXEC : RESP;
                end
            end
            EXEC:    state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                if (bus.ResReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_fun_sel <= '0;
            alu_wf      <= 1'b0;
            res_data    <= '0;
            res_tag     <= '0;
            res_skipped <= 1'b0;
            flags       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.InstrValid) begin
                        res_tag <= bus.InstrTag;
                        if (take) begin
                            alu_a       <= bus.InstrA;
                            alu_b       <= bus.InstrB;
                            alu_fun_sel <= bus.InstrFunSel;
                            alu_wf      <= bus.InstrWF;
                        end else begin
                            // Skipped: ALU-side registers keep their last issued values.
                            res_skipped <= 1'b1;
                            res_data    <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    res_data    <= bus.AluOut;
                    res_skipped <= 1'b0;
                    if (alu_wf) begin
                        flags <= bus.AluFlags;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is gated by Reset so it drops the moment reset asserts.
    assign bus.InstrReady = (state == IDLE) && !Reset;
    assign bus.ResValid   = (state == RESP);
    assign bus.AluA       = alu_a;
    assign bus.AluB       = alu_b;
    assign bus.AluFunSel  = alu_fun_sel;
    assign bus.AluWF      = alu_wf;
    assign bus.ResData    = res_data;
    assign bus.ResTag     = res_tag;
    assign bus.ResSkipped = res_skipped;
    assign bus.Flags      = flags;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer with a
// behavioural 1-cycle registered ALU and bench-driven ALU flags.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    alu_op_sequencer_if #(.WIDTH(16), .TAG_W(3)) bus ();

    alu_op_sequencer #(.WIDTH(16), .TAG_W(3)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  tag;
        logic        skip;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  exp_flags = 4'b0000;
    logic [3:0]  model_flags = 4'b0000;
    logic [15:0] alu_out;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;

    function automatic logic [15:0] alu_fn(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b);
        case (fs)
            5'b10100: return a + b;
            5'b00011: return a - b;
            default:  return a ^ b;
        endcase
    endfunction

    // Flag word is Z C N O = [3:0].
    function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[3];
            3'd2: return !f[3];
            3'd3: return f[2];
            3'd4: return !f[2];
            3'd5: return f[1];
            3'd6: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge Clock) alu_out <= alu_fn(bus.AluFunSel, bus.AluA, bus.AluB);
    always @(posedge Clock) cyc_cnt <= cyc_cnt + 1;
    assign bus.AluOut   = alu_out;
    assign bus.AluFlags = model_flags;

    // Drives one request (DUT assumed idle), pushes its expectation, returns
    // #1 after the accepting edge.
    task automatic issue(input logic [4:0] fs, input logic wf, input logic [2:0] cond,
                         input logic [2:0] tag, input logic [15:0] a, input logic [15:0] b,
                         output int acc);
        exp_t e;
        logic t;
        t       = cond_true(cond, exp_flags);
        e.tag   = tag;
        e.skip  = !t;
        e.data  = t ? alu_fn(fs, a, b) : 16'h0000;
        if (t && wf) exp_flags = model_flags;
        e.flags = exp_flags;
        e.lat   = t ? 2 : 0;
        sb.push_back(e);
        bus.InstrFunSel = fs;
        bus.InstrWF     = wf;
        bus.InstrCond   = cond;
        bus.InstrTag    = tag;
        bus.InstrA      = a;
        bus.InstrB      = b;
        bus.InstrValid  = 1'b1;
        @(posedge Clock);
        #1;
        acc = cyc_cnt;
        bus.InstrValid = 1'b0;
    endtask

    // Counts edges after the accept until ResValid, bounded.
    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (bus.ResValid !== 1'b1 && cyc < 20) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if ({bus.InstrReady, bus.ResValid, bus.AluA, bus.AluB, bus.AluFunSel, bus.AluWF,
             bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b val=%b a=%h b=%h fs=%b wf=%b d=%h t=%h s=%b f=%b, want all zero",
                     bus.InstrReady, bus.ResValid, bus.AluA, bus.AluB, bus.AluFunSel, bus.AluWF,
                     bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags);
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.InstrReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", bus.InstrReady);
        end
    endtask

    task automatic test_basic_add();
        int acc, lat;
        exp_t e;
        model_flags = 4'b0000;
        issue(5'b10100, 1'b1, 3'b000, 3'd5, 16'h0003, 16'h0004, acc);
        wait_resp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL add_latency: got %0d want 2", lat);
        end
        checks++;
        if ({bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== {16'h0007, 3'd5, 1'b0, 4'b0000}
            || e.data !== 16'h0007) begin
            errors++;
            $display("FAIL add_result: got d=%h t=%0d s=%b f=%b want d=0007 t=5 s=0 f=0000",
                     bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_wf_gating();
        int acc, lat;
        exp_t e;
        model_flags = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            issue(5'b01111, (i == 1), 3'b000, 3'(i + 1), 16'h5A5A, 16'h0FF0, acc);
            wait_resp(lat);
            e = sb.pop_front();
            checks++;
            if ({bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== {e.data, e.tag, e.skip, e.flags}) begin
                errors++;
                $display("FAIL wf_gating_%0d: got d=%h t=%0d s=%b f=%b want d=%h t=%0d s=%b f=%b", i,
                         bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags, e.data, e.tag, e.skip, e.flags);
            end
            @(posedge Clock);
            #1;
        end
        checks++;
        if (bus.Flags !== 4'b1000) begin
            errors++;
            $display("FAIL wf_flags_written: got %b want 1000", bus.Flags);
        end
    endtask

    task automatic test_cond_exec();
        int acc, lat;
        exp_t e;
        model_flags = 4'b1000;
        // Cond Z with Z set: executes.
        issue(5'b00011, 1'b0, 3'b001, 3'd1, 16'h0010, 16'h0003, acc);
        checks++;
        if (bus.AluFunSel !== 5'b00011) begin
            errors++;
            $display("FAIL cond_z_funsel: got %b want 00011", bus.AluFunSel);
        end
        wait_resp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || {bus.ResData, bus.ResSkipped} !== {e.data, e.skip}) begin
            errors++;
            $display("FAIL cond_z_result: got lat=%0d d=%h s=%b want lat=%0d d=%h s=%b",
                     lat, bus.ResData, bus.ResSkipped, e.lat, e.data, e.skip);
        end
        @(posedge Clock);
        #1;
        // Cond !Z with Z set: skipped.
        issue(5'b01010, 1'b1, 3'b010, 3'd2, 16'hFFFF, 16'h1111, acc);
        wait_resp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL cond_nz_latency: got %0d want 0 edges after accept", lat);
        end
        checks++;
        if ({bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags, bus.AluFunSel} !==
            {16'h0000, 3'd2, 1'b1, 4'b1000, 5'b00011}) begin
            errors++;
            $display("FAIL cond_nz_skip: got d=%h t=%0d s=%b f=%b fs=%b want d=0000 t=2 s=1 f=1000 fs=00011",
                     bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags, bus.AluFunSel);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_never();
        int acc, lat;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            model_flags = (i == 0) ? 4'b1111 : 4'b0000;
            issue(5'b10100, 1'b1, 3'b111, 3'(6 + i), 16'h1234, 16'h4321, acc);
            wait_resp(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== 0 || {bus.ResData, bus.ResTag, bus.ResSkipped} !== {16'h0000, e.tag, 1'b1}) begin
                errors++;
                $display("FAIL never_%0d: got lat=%0d d=%h t=%0d s=%b want lat=0 d=0000 t=%0d s=1",
                         i, lat, bus.ResData, bus.ResTag, bus.ResSkipped, e.tag);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int acc, lat;
        exp_t e;
        logic [15:0] d0;
        logic [2:0]  t0;
        model_flags = 4'b0000;
        bus.ResReady = 1'b0;
        issue(5'b00001, 1'b0, 3'b000, 3'd3, 16'hA0A0, 16'h0B0B, acc);
        wait_resp(lat);
        e = sb.pop_front();
        checks++;
        if ({bus.ResData, bus.ResTag} !== {e.data, e.tag}) begin
            errors++;
            $display("FAIL bp_result: got d=%h t=%0d want d=%h t=%0d", bus.ResData, bus.ResTag, e.data, e.tag);
        end
        d0 = bus.ResData;
        t0 = bus.ResTag;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            checks++;
            if ({bus.ResValid, bus.ResData, bus.ResTag, bus.InstrReady} !== {1'b1, d0, t0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h t=%0d rdy=%b want v=1 d=%h t=%0d rdy=0",
                         i, bus.ResValid, bus.ResData, bus.ResTag, bus.InstrReady, d0, t0);
            end
        end
        bus.ResReady = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if ({bus.InstrReady, bus.ResValid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", bus.InstrReady, bus.ResValid);
        end
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        exp_t e;
        bit seen;
        model_flags = 4'b0110;
        issue(5'b10100, 1'b1, 3'b000, 3'd4, 16'h1234, 16'h1111, acc);
        checks++;
        if (bus.AluA !== 16'h1234) begin
            errors++;
            $display("FAIL mid_exec_alua: got %h want 1234", bus.AluA);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({bus.InstrReady, bus.ResValid, bus.AluA, bus.AluB, bus.AluFunSel, bus.AluWF,
             bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy=%b v=%b a=%h b=%h fs=%b wf=%b d=%h t=%0d s=%b f=%b want all zero",
                     bus.InstrReady, bus.ResValid, bus.AluA, bus.AluB, bus.AluFunSel, bus.AluWF,
                     bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags);
        end
        void'(sb.pop_back());
        exp_flags = 4'b0000;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            if (bus.ResValid !== 1'b0 || bus.Flags !== 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_dropped: got stray response or flag update, want none");
        end
        model_flags = 4'b0010;
        issue(5'b10100, 1'b1, 3'b000, 3'd7, 16'h0100, 16'h0023, acc);
        wait_resp(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== 2 || {bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== {16'h0123, 3'd7, 1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d d=%h t=%0d s=%b f=%b want lat=2 d=0123 t=7 s=0 f=0010",
                     lat, bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int acc, prev_acc, lat;
        bit prev_exec;
        exp_t e;
        prev_acc  = 0;
        prev_exec = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_flags = 4'($urandom_range(0, 15));
            issue(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'(i), 16'($urandom), 16'($urandom), acc);
            if (i > 0) begin
                checks++;
                if (acc - prev_acc !== (prev_exec ? 4 : 2)) begin
                    errors++;
                    $display("FAIL b2b_interval_%0d: got %0d want %0d", i, acc - prev_acc, prev_exec ? 4 : 2);
                end
            end
            wait_resp(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || {bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags} !== {e.data, e.tag, e.skip, e.flags}) begin
                errors++;
                $display("FAIL b2b_result_%0d: got lat=%0d d=%h t=%0d s=%b f=%b want lat=%0d d=%h t=%0d s=%b f=%b",
                         i, lat, bus.ResData, bus.ResTag, bus.ResSkipped, bus.Flags,
                         e.lat, e.data, e.tag, e.skip, e.flags);
            end
            prev_acc  = acc;
            prev_exec = !e.skip;
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        bus.InstrValid  = 1'b0;
        bus.InstrFunSel = '0;
        bus.InstrWF     = 1'b0;
        bus.InstrCond   = '0;
        bus.InstrTag    = '0;
        bus.InstrA      = '0;
        bus.InstrB      = '0;
        bus.ResReady    = 1'b1;
        test_reset();
        test_basic_add();
        test_wf_gating();
        test_cond_exec();
        test_never();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
